unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the RISCVpipeline instruction-fetch port and data-memory port.
- Sequences each access with a request/grant/response handshake and returns read data to the winning requester.
- Tells the pipeline when a requester has been serviced; the pipeline holds that requester stalled until then.
- Data accesses have priority; instruction fetch has a bounded-starvation guarantee and each access has a response timeout.

Parameters:
XLEN, 32, data width of all read/write data buses
ALEN, 32, address width
MAX_D_BURST, 4, consecutive data grants allowed while if_req is pending before fetch must win
TIMEOUT, 64, cycles in WAIT without mem_rvalid before the access is aborted

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held until if_valid
if_addr  in  ALEN  fetch address, stable while if_req
if_rdata  out  XLEN  fetched instruction, valid with if_valid
if_valid  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request, held until dm_valid
dm_we  in  1  1 = store, 0 = load
dm_be  in  XLEN/8  byte enables for stores
dm_addr  in  ALEN  data address
dm_wdata  in  XLEN  store data
dm_rdata  out  XLEN  load data, valid with dm_valid
dm_valid  out  1  one-cycle completion pulse for data (loads and stores)
mem_req  out  1  memory request, held until mem_gnt
mem_we  out  1  write strobe to memory
mem_be  out  XLEN/8  byte enables to memory (all ones for fetch)
mem_addr  out  ALEN  memory address
mem_wdata  out  XLEN  memory write data
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  memory completion (reads and writes), at least 1 cycle after grant
mem_rdata  in  XLEN  memory read data, valid with mem_rvalid
err  out  1  one-cycle pulse with the valid of a timed-out access

Behaviour:
- Reset: state IDLE. All outputs are 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_valid, dm_valid, if_rdata, dm_rdata, err. Burst counter and timeout counter are 0. Reset mid-access abandons the access immediately; no valid is produced.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: owner selection.
  - If dm_req and (burst_cnt < MAX_D_BURST or !if_req), owner = DATA.
  - Else if if_req, owner = INSTR.
  - Else stay in IDLE.
  - On selection, latch the owner's address, we, be and wdata into the mem_* registers, set mem_req = 1, and go to ISSUE.
  - A fetch always drives mem_we = 0 and mem_be = all ones.
- Burst counter:
  - DATA selected while if_req = 1: increment, saturating at MAX_D_BURST.
  - INSTR selected: clear to 0.
  - DATA selected with if_req = 0: clear to 0.
- ISSUE: hold mem_* stable. On mem_gnt, clear mem_req, clear the timeout counter, and go to WAIT. There is no timeout in ISSUE.
- WAIT:
  - On mem_rvalid, capture mem_rdata into the owner's rdata register, pulse the owner's valid in the next cycle, and go to RESP.
  - If the timeout counter reaches TIMEOUT-1 without mem_rvalid, go to RESP with owner rdata = 0 and err = 1.
- RESP: valid and err are high for exactly this cycle, then go to IDLE. IDLE samples requests no earlier than the cycle after RESP, so a requester's stale req seen while it observes valid is never re-serviced.
- Minimum latency: req sampled in cycle 0, mem_req high in cycle 1 (gnt in cycle 1), rvalid in cycle 2, valid in cycle 3, IDLE in cycle 4. An access therefore completes every 4 cycles back-to-back.
- rdata registers hold their value until the next completion for that port.
- mem_rvalid or mem_gnt arriving in IDLE or RESP is ignored.
- Simultaneous if_req and dm_req in IDLE: DATA wins unless the burst limit is reached.
- Only one access is outstanding at any time.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the owner enum (OWN_INSTR, OWN_DATA);
  - the FETCH_BE all-ones constant;
  - the default XLEN/ALEN constants.
- Single module. The timeout counter and burst counter are small enough to stay inline; no sub-module is warranted.

Test Plan:
- Single load: dm_req, dm_we=0, dm_addr=0x100; memory grants immediately and returns rvalid=1 with rdata=0xDEADBEEF one cycle after grant -> mem_addr=0x100, mem_we=0 in cycle 1, dm_valid=1 with dm_rdata=0xDEADBEEF in cycle 3, if_valid stays 0.
- Store: dm_we=1, dm_be=4'b0011, dm_wdata=0x1234ABCD, addr 0x200 -> mem_we=1, mem_be=0011, mem_wdata=0x1234ABCD, dm_valid pulses once.
- Contention: if_req and dm_req both held, memory always grants and responds immediately -> order is D,D,D,D,I,D,D,D,D,I, and each valid is exactly 1 cycle wide.
- Grant backpressure: mem_gnt held 0 for 5 cycles -> mem_req and mem_* stay stable for all 6 cycles, and no valid is produced until rvalid.
- Timeout: fetch granted, rvalid never arrives -> after 64 cycles in WAIT, if_valid=1, err=1, if_rdata=0, then the block returns to IDLE.
- Reset mid-WAIT: assert reset with a load outstanding, then a late mem_rvalid arrives -> all outputs are 0 after the reset edge, no dm_valid is produced, and the stray rvalid is ignored in IDLE.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared types and constants for the unified memory arbiter.
// Holds the arbiter FSM state encoding, the owner tag and the default bus widths.
// FETCH_BE is the all-ones byte-enable that an instruction fetch presents at the default XLEN.
package riscv_mem_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ALEN_DEF = 32;

  localparam logic [XLEN_DEF/8-1:0] FETCH_BE = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: one single-ported memory shared by the fetch port (if_*) and the data port
// (dm_*). Data has priority, but after MAX_D_BURST back-to-back data grants with a fetch waiting,
// the fetch wins the next slot. One access in flight; best case 4 cycles per access.
// Ports: if_req/if_addr -> if_rdata/if_valid; dm_req/we/be/addr/wdata -> dm_rdata/dm_valid;
//        mem_req/we/be/addr/wdata held until mem_gnt, then mem_rvalid/mem_rdata completes it;
//        err pulses with the valid of an access that saw no mem_rvalid within TIMEOUT cycles.
module unified_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int ALEN        = ALEN_DEF,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ALEN-1:0]   if_addr,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_valid,
  // data port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [XLEN/8-1:0] dm_be,
  input  logic [ALEN-1:0]   dm_addr,
  input  logic [XLEN-1:0]   dm_wdata,
  output logic [XLEN-1:0]   dm_rdata,
  output logic              dm_valid,
  // memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [ALEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  // timeout indication
  output logic              err
);

  localparam int BEW = XLEN / 8;
  localparam int BCW = $clog2(MAX_D_BURST + 1);
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [BCW-1:0] BURST_MAX = BCW'(MAX_D_BURST);
  localparam logic [TCW-1:0] TC_LAST   = TCW'(TIMEOUT - 1);

  state_t         state;
  owner_t         owner;
  logic [BCW-1:0] burst_cnt;
  logic [TCW-1:0] tcnt;
  logic           pick_data;

  // Data wins unless a fetch is waiting and the data burst allowance is used up.
  assign pick_data = dm_req && ((burst_cnt < BURST_MAX) || !if_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_INSTR;
      burst_cnt <= '0;
      tcnt      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_rdata  <= '0;
      dm_valid  <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_data) begin
            owner     <= OWN_DATA;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_be    <= dm_be;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            state     <= ISSUE;
            // With a fetch waiting, pick_data implies burst_cnt < BURST_MAX,
            // so the increment can never pass the saturation value.
            burst_cnt <= if_req ? burst_cnt + 1'b1 : '0;
          end else if (if_req) begin
            owner     <= OWN_INSTR;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= {BEW{1'b1}};
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            state     <= ISSUE;
            burst_cnt <= '0;
          end
        end

        ISSUE: begin
          // mem_* stay untouched until the memory accepts; no timeout here.
          if (mem_gnt) begin
            mem_req <= 1'b0;
            tcnt    <= '0;
            state   <= WAIT;
          end
        end

        WAIT: begin
          if (mem_rvalid) begin
            if (owner == OWN_DATA) begin
              dm_rdata <= mem_rdata;
              dm_valid <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
            state <= RESP;
          end else if (tcnt == TC_LAST) begin
            // Abort: complete the access with zero data and flag it.
            if (owner == OWN_DATA) begin
              dm_rdata <= '0;
              dm_valid <= 1'b1;
            end else begin
              if_rdata <= '0;
              if_valid <= 1'b1;
            end
            err   <= 1'b1;
            state <= RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        RESP: begin
          // One-cycle pulses. Requests are not sampled here so the requester
          // that is just seeing its valid cannot be picked again on a stale req.
          if_valid <= 1'b0;
          dm_valid <= 1'b0;
          err      <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
